rcl_query_feeder: RTL

//  Upstream stage of the circle/line relation unit (RCL). Accepts whole queries
//  (line a,b,c; circle m,n,k) on a valid/ready port and buffers them in a small FIFO.

---
 rtl/rcl_pkg.sv | 38 +++
 rtl/rcl_sync_fifo.sv | 69 ++++++
 rtl/rcl_query_feeder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/rcl_pkg.sv
// Shared types and constants for the RCL query feeder: FSM states, relation codes,
// coefficient width, burst length and the packed query record.
package rcl_pkg;

    localparam int COEF_W  = 5;
    localparam int BEATS   = 3;
    localparam int QUERY_W = 6 * COEF_W;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT
    } state_t;

    localparam logic [1:0] REL_OUTSIDE = 2'd0;
    localparam logic [1:0] REL_TANGENT = 2'd1;
    localparam logic [1:0] REL_SECANT  = 2'd2;
    localparam logic [1:0] REL_TIMEOUT = 2'd3;

    typedef struct packed {
        logic signed [COEF_W-1:0] a;
        logic signed [COEF_W-1:0] b;
        logic signed [COEF_W-1:0] c;
        logic signed [COEF_W-1:0] m;
        logic signed [COEF_W-1:0] n;
        logic        [COEF_W-1:0] k;
    } query_t;

    // Returns {coef_L, coef_Q} for one beat of the burst.
    function automatic logic [2*COEF_W-1:0] beat_coefs(input query_t q, input logic [1:0] beat);
        case (beat)
            2'd0:    beat_coefs = {q.a, q.m};
            2'd1:    beat_coefs = {q.b, q.n};
            default: beat_coefs = {q.c, q.k};
        endcase
    endfunction

endpackage

// File: rtl/rcl_sync_fifo.sv
// Synchronous FIFO for whole queries; count-based full/empty, sync active-low reset.
module rcl_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 30
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A push while full is dropped even if a pop frees a slot in the same cycle.
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/rcl_query_feeder.sv
// Buffers queries and serialises each into a 3-beat burst for RCL, one query in flight.
// Optional WAIT-state timeout is enabled by defining RCL_FEEDER_TIMEOUT_EN.
module rcl_query_feeder
    import rcl_pkg::*;
#(
    parameter int          DEPTH   = 4,
    parameter int          TAG_W   = 4,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              q_valid,
    output logic              q_ready,
    input  logic [COEF_W-1:0] q_a,
    input  logic [COEF_W-1:0] q_b,
    input  logic [COEF_W-1:0] q_c,
    input  logic [COEF_W-1:0] q_m,
    input  logic [COEF_W-1:0] q_n,
    input  logic [COEF_W-1:0] q_k,
    output logic              in_valid,
    output logic [COEF_W-1:0] coef_L,
    output logic [COEF_W-1:0] coef_Q,
    input  logic              rcl_out_valid,
    input  logic [1:0]        rcl_out,
    output logic              res_valid,
    output logic [1:0]        res_rel,
    output logic [TAG_W-1:0]  res_tag
);

    state_t             state_q, state_d;
    logic [1:0]         beat_q, beat_d;
    query_t             hold_q, hold_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               in_valid_q, in_valid_d;
    logic [COEF_W-1:0]  coef_l_q, coef_l_d;
    logic [COEF_W-1:0]  coef_q_q, coef_q_d;
    logic               res_valid_q, res_valid_d;
    logic [1:0]         res_rel_q, res_rel_d;
    logic [TAG_W-1:0]   res_tag_q, res_tag_d;

    query_t             fifo_head;
    logic               fifo_full, fifo_empty, fifo_pop;
    logic [$clog2(DEPTH):0] unused_fifo_count;

`ifdef RCL_FEEDER_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT + 1);
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    assign q_ready   = rst_n && !fifo_full;
    assign in_valid  = in_valid_q;
    assign coef_L    = coef_l_q;
    assign coef_Q    = coef_q_q;
    assign res_valid = res_valid_q;
    assign res_rel   = res_rel_q;
    assign res_tag   = res_tag_q;

    rcl_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (QUERY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (q_valid && q_ready),
        .wr_data ({q_a, q_b, q_c, q_m, q_n, q_k}),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (unused_fifo_count)
    );

    // Beat 0 comes straight from the FIFO head; beats 1-2 from the holding register.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        hold_d      = hold_q;
        tag_d       = tag_q;
        in_valid_d  = 1'b0;
        coef_l_d    = '0;
        coef_q_d    = '0;
        res_valid_d = 1'b0;
        res_rel_d   = res_rel_q;
        res_tag_d   = res_tag_q;
        fifo_pop    = 1'b0;
`ifdef RCL_FEEDER_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop               = 1'b1;
                    hold_d                 = fifo_head;
                    in_valid_d             = 1'b1;
                    {coef_l_d, coef_q_d}   = beat_coefs(fifo_head, 2'd0);
                    beat_d                 = 2'd1;
                    state_d                = SEND;
                end
            end
            SEND: begin
                if (beat_q == 2'(BEATS)) begin
                    state_d = WAIT;
`ifdef RCL_FEEDER_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                end else begin
                    in_valid_d             = 1'b1;
                    {coef_l_d, coef_q_d}   = beat_coefs(hold_q, beat_q);
                    beat_d                 = beat_q + 2'd1;
                end
            end
            WAIT: begin
                if (rcl_out_valid) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b1;
                    res_rel_d   = rcl_out;
                    res_tag_d   = tag_q;
                    tag_d       = tag_q + TAG_W'(1);
                end
`ifdef RCL_FEEDER_TIMEOUT_EN
                else if (wait_cnt_q == WCW'(TIMEOUT - 1)) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b1;
                    res_rel_d   = REL_TIMEOUT;
                    res_tag_d   = tag_q;
                    tag_d       = tag_q + TAG_W'(1);
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            hold_q      <= '0;
            tag_q       <= '0;
            in_valid_q  <= 1'b0;
            coef_l_q    <= '0;
            coef_q_q    <= '0;
            res_valid_q <= 1'b0;
            res_rel_q   <= REL_OUTSIDE;
            res_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            hold_q      <= hold_d;
            tag_q       <= tag_d;
            in_valid_q  <= in_valid_d;
            coef_l_q    <= coef_l_d;
            coef_q_q    <= coef_q_d;
            res_valid_q <= res_valid_d;
            res_rel_q   <= res_rel_d;
            res_tag_q   <= res_tag_d;
        end
    end

`ifdef RCL_FEEDER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

endmodule
